// File: rtl/cale_de_date_div.sv
// Sequential restoring shift-subtract divider: one quotient bit per clock,
// width iterations per operation, divide-by-zero short-circuited to DONE.
module cale_de_date_div #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] OpA,
  input  logic [width-1:0] OpB,
  output logic [width-1:0] quot,
  output logic [width-1:0] rem,
  output logic             busy,
  output logic             ready,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(width) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  // Guard bit of the partial remainder is kept only in the trial value:
  // a restoring step always leaves R < B, so the stored top bit is always 0.
  logic [width-1:0] r_q, r_d;
  logic [width-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [width:0]   trial;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ready_d = ready_q;
    trial   = {r_q, a_q[width-1]};

    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          if (OpB != '0) begin
            a_d     = OpA;
            b_d     = OpB;
            r_d     = '0;
            q_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            ready_d = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = '1;
            r_d     = OpA;
            dbz_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (trial >= {1'b0, b_q}) begin
          r_d = width'(trial - {1'b0, b_q});
          q_d = {q_q[width-2:0], 1'b1};
        end else begin
          r_d = trial[width-1:0];
          q_d = {q_q[width-2:0], 1'b0};
        end
        a_d   = {a_q[width-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(width - 1)) begin
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign quot  = q_q;
  assign rem   = r_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_cale_de_date_div.sv
// Self-checking bench for cale_de_date_div against plain integer division.
module tb_cale_de_date_div;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] OpA, OpB;
  logic [7:0] quot, rem;
  logic       busy, ready, dbz;

  int checks = 0;
  int passes = 0;

  cale_de_date_div #(.width(8)) dut (
    .clk(clk), .reset(reset), .load(load), .OpA(OpA), .OpB(OpB),
    .quot(quot), .rem(rem), .busy(busy), .ready(ready), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and waits (bounded) for ready; lat counts edges
  // after the accepting edge. Expects to be entered just after an edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output bit overlap, output bit saw_busy);
    OpA = a; OpB = b; load = 1'b1;
    step();
    load = 1'b0;
    lat = 0;
    overlap = busy && ready;
    saw_busy = busy;
    while (!ready && lat < 40) begin
      step();
      lat++;
      if (busy && ready) overlap = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; OpA = 8'd100; OpB = 8'd7;
    step(); step();
    checks++;
    if ({quot, rem, busy, ready, dbz} !== 19'd0)
      $display("FAIL reset_outputs: quot=%0d rem=%0d busy=%b ready=%b dbz=%b, expected all 0",
               quot, rem, busy, ready, dbz);
    else passes++;
    reset = 1'b0; load = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset_idle: busy=%b ready=%b, expected 0 0", busy, ready);
    else passes++;
  endtask

  task automatic test_basic();
    int lat; bit ov, sb;
    do_op(8'd100, 8'd7, lat, ov, sb);
    checks++;
    if (quot !== 8'd14 || rem !== 8'd2 || dbz !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_100_7: quot=%0d rem=%0d dbz=%b busy=%b, expected 14 2 0 0",
               quot, rem, dbz, busy);
    else passes++;
    checks++;
    if (lat !== 8 || ov)
      $display("FAIL basic_latency: lat=%0d overlap=%b, expected 8 0", lat, ov);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (quot !== 8'd14 || rem !== 8'd2 || ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL basic_hold%0d: quot=%0d rem=%0d ready=%b busy=%b, expected 14 2 1 0",
                 i, quot, rem, ready, busy);
      else passes++;
    end
  endtask

  task automatic test_edges();
    logic [7:0] av [4] = '{8'd255, 8'd3, 8'd255, 8'd0};
    logic [7:0] bv [4] = '{8'd1, 8'd10, 8'd255, 8'd9};
    int lat; bit ov, sb;
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], lat, ov, sb);
      checks++;
      if (quot !== av[i] / bv[i] || rem !== av[i] % bv[i] || dbz !== 1'b0 || lat !== 8)
        $display("FAIL edge_%0d_%0d: quot=%0d rem=%0d dbz=%b lat=%0d, expected %0d %0d 0 8",
                 av[i], bv[i], quot, rem, dbz, lat, av[i] / bv[i], av[i] % bv[i]);
      else passes++;
    end
  endtask

  task automatic test_dbz();
    int lat; bit ov, sb;
    do_op(8'd5, 8'd0, lat, ov, sb);
    checks++;
    if (lat !== 0 || ready !== 1'b1 || dbz !== 1'b1 || quot !== 8'hFF || rem !== 8'd5 || sb)
      $display("FAIL dbz_5_0: lat=%0d ready=%b dbz=%b quot=%0h rem=%0d busy_seen=%b, expected 0 1 1 ff 5 0",
               lat, ready, dbz, quot, rem, sb);
    else passes++;
    step();
    checks++;
    if (ready !== 1'b1 || dbz !== 1'b1 || busy !== 1'b0 || quot !== 8'hFF)
      $display("FAIL dbz_hold: ready=%b dbz=%b busy=%b quot=%0h, expected 1 1 0 ff",
               ready, dbz, busy, quot);
    else passes++;
  endtask

  task automatic test_load_during_run();
    int lat;
    OpA = 8'd200; OpB = 8'd13; load = 1'b1;
    step();
    load = 1'b0;
    lat = 0;
    while (!ready && lat < 40) begin
      if (lat == 3) begin OpA = 8'd9; OpB = 8'd3; load = 1'b1; end
      step();
      load = 1'b0;
      lat++;
    end
    checks++;
    if (quot !== 8'd15 || rem !== 8'd5 || lat !== 8 || dbz !== 1'b0)
      $display("FAIL load_in_run: quot=%0d rem=%0d lat=%0d dbz=%b, expected 15 5 8 0",
               quot, rem, lat, dbz);
    else passes++;
  endtask

  task automatic test_reset_mid_op();
    int lat; bit ov, sb;
    OpA = 8'd100; OpB = 8'd7; load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({quot, rem, busy, ready, dbz} !== 19'd0)
      $display("FAIL reset_mid_op: quot=%0d rem=%0d busy=%b ready=%b dbz=%b, expected all 0",
               quot, rem, busy, ready, dbz);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset_mid_idle: busy=%b ready=%b, expected 0 0", busy, ready);
    else passes++;
    do_op(8'd50, 8'd6, lat, ov, sb);
    checks++;
    if (quot !== 8'd8 || rem !== 8'd2 || lat !== 8)
      $display("FAIL after_reset_50_6: quot=%0d rem=%0d lat=%0d, expected 8 2 8", quot, rem, lat);
    else passes++;
  endtask

  task automatic test_back_to_back();
    OpA = 8'd77; OpB = 8'd5; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1 || dbz !== 1'b0)
      $display("FAIL b2b_restart: ready=%b busy=%b dbz=%b, expected 0 1 0", ready, busy, dbz);
    else passes++;
  endtask

  task automatic test_random();
    int lat; bit ov, sb;
    logic [7:0] a, b;
    int unsigned ea, eq, er;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      do_op(a, b, lat, ov, sb);
      ea = a; eq = a / b; er = a % b;
      checks++;
      if (quot !== 8'(eq) || rem !== 8'(er) || dbz !== 1'b0)
        $display("FAIL rand_%0d_%0d: quot=%0d rem=%0d dbz=%b, expected %0d %0d 0",
                 a, b, quot, rem, dbz, eq, er);
      else passes++;
      checks++;
      if (ea !== int'(quot) * int'(b) + int'(rem) || rem >= b)
        $display("FAIL rand_invariant_%0d_%0d: quot=%0d rem=%0d", a, b, quot, rem);
      else passes++;
      checks++;
      if (lat !== 8 || ov)
        $display("FAIL rand_latency_%0d_%0d: lat=%0d overlap=%b, expected 8 0", a, b, lat, ov);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; OpA = '0; OpB = '0;
    #1;
    test_reset();
    test_basic();
    test_edges();
    test_dbz();
    test_back_to_back();
    repeat (12) step();
    test_load_during_run();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
